// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-time program loader.
// The loader drives the slave modport; the UART side and the fetch stage see the master side.
interface inst_loader_if #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int INST_WIDTH     = 32
);
    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      restart;
    logic                      we;
    logic [INST_MEM_WIDTH-1:0] waddr;
    logic [INST_WIDTH-1:0]     wdata;
    logic                      core_hold;
    logic                      err;

    modport master (
        output in_data, in_valid, restart,
        input  in_ready, we, waddr, wdata, core_hold, err
    );

    modport slave (
        input  in_data, in_valid, restart,
        output in_ready, we, waddr, wdata, core_hold, err
    );
endinterface

// File: rtl/inst_loader.sv
// Boot-time program loader: parses a big-endian word count plus N words and writes them to inst-mem.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int INST_WIDTH     = 32
) (
    input logic          clk,
    input logic          reset_n,
    inst_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {HDR, DATA, DONE, ERR} state_t;
`endif

    localparam logic [32:0] CAPACITY = 33'd1 << INST_MEM_WIDTH;

    state_t                    state;
    logic [1:0]                byte_cnt;
    logic [INST_MEM_WIDTH:0]   word_cnt;
    logic [31:0]               count;
    logic [INST_WIDTH-9:0]     word_asm;
    logic                      we;
    logic [INST_MEM_WIDTH-1:0] waddr;
    logic [INST_WIDTH-1:0]     wdata;
    logic                      core_hold;
    logic                      err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                csum;
`endif

    logic                      in_ready;
    logic                      accept;
    logic [31:0]               next_count;
    logic [INST_WIDTH-1:0]     next_word;
    logic                      last_word;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            HDR, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM:      in_ready = 1'b1;
`endif
            default:   in_ready = 1'b0;
        endcase
        if (bus.restart)
            in_ready = 1'b0;
    end

    assign accept     = bus.in_valid && in_ready;
    assign next_count = {count[23:0], bus.in_data};
    assign next_word  = {word_asm, bus.in_data};
    assign last_word  = (32'(word_cnt) == (count - 32'd1));

    // The count is checked against capacity, so word_cnt can never address beyond the memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HDR;
            byte_cnt  <= 2'd0;
            word_cnt  <= '0;
            count     <= 32'd0;
            word_asm  <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            core_hold <= 1'b1;
            err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            we <= 1'b0;
            if (bus.restart) begin
                state     <= HDR;
                byte_cnt  <= 2'd0;
                word_cnt  <= '0;
                count     <= 32'd0;
                core_hold <= 1'b1;
                err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                csum      <= 8'd0;
`endif
            end else if (accept) begin
                case (state)
                    HDR: begin
                        count    <= next_count;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (next_count == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state     <= CSUM;
`else
                                state     <= DONE;
                                core_hold <= 1'b0;
`endif
                            end else if ({1'b0, next_count} > CAPACITY) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else begin
                                state    <= DATA;
                                word_cnt <= '0;
                            end
                        end
                    end
                    DATA: begin
                        word_asm <= next_word[INST_WIDTH-9:0];
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            we       <= 1'b1;
                            wdata    <= next_word;
                            waddr    <= word_cnt[INST_MEM_WIDTH-1:0];
                            word_cnt <= word_cnt + 1'b1;
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state     <= CSUM;
`else
                                state     <= DONE;
                                core_hold <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    // Words are already in memory on a mismatch; only the hold keeps them from running.
                    CSUM: begin
                        if (csum == bus.in_data) begin
                            state     <= DONE;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.we        = we;
    assign bus.waddr     = waddr;
    assign bus.wdata     = wdata;
    assign bus.core_hold = core_hold;
    assign bus.err       = err;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed images plus random ones against a queue-based model.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int W = 14;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    inst_loader_if #(.INST_MEM_WIDTH(W), .INST_WIDTH(32)) bus ();
    inst_loader #(.INST_MEM_WIDTH(W), .INST_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] img_words[$];
    logic [7:0]  tx_bytes[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    logic        got_hold[$];
    int          cyc = 0;
    int          last_we_cyc = -100;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor; strobes must be at least 4 cycles apart.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && bus.we === 1'b1) begin
            check_output("we_spacing", 64'(cyc - last_we_cyc >= 4), 64'd1);
            last_we_cyc <= cyc;
            got_addr.push_back(int'(bus.waddr));
            got_data.push_back(bus.wdata);
            got_hold.push_back(bus.core_hold);
        end
    end

    // Reference image: header, big-endian words, optional XOR of payload bytes.
    task automatic build_image(input bit bad_csum);
        logic [31:0] n;
        logic [7:0]  x;
        n = 32'(img_words.size());
        x = 8'd0;
        tx_bytes.delete();
        for (int i = 3; i >= 0; i--) tx_bytes.push_back(n[i*8 +: 8]);
        foreach (img_words[k]) begin
            for (int i = 3; i >= 0; i--) begin
                tx_bytes.push_back(img_words[k][i*8 +: 8]);
                x = x ^ img_words[k][i*8 +: 8];
            end
        end
        if (CSUM_ON) tx_bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        #1;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) check_output("ready_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
    endtask

    // mode 0: back-to-back, 1: in_valid toggling, 2: random gaps
    task automatic apply_stimulus(input int mode);
        foreach (tx_bytes[i]) begin
            int gap;
            gap = (mode == 0) ? 0 : (mode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 3));
            send_byte(tx_bytes[i], gap);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        #1;
        check_output("restart_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.restart = 1'b0;
        #1;
        check_output("restart_hold", 64'(bus.core_hold), 64'd1);
        check_output("restart_err", 64'(bus.err), 64'd0);
        check_output("restart_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_image(input int mode, input bit bad_csum, input string tag);
        int n;
        n = img_words.size();
        got_addr.delete();
        got_data.delete();
        got_hold.delete();
        build_image(bad_csum);
        apply_stimulus(mode);
        repeat (4) @(negedge clk);
        check_output({tag, "_count"}, 64'(got_addr.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_addr.size()) begin
                check_output({tag, "_waddr"}, 64'(got_addr[i]), 64'(i));
                check_output({tag, "_wdata"}, 64'(got_data[i]), 64'(img_words[i]));
                check_output({tag, "_hold_at_we"}, 64'(got_hold[i]),
                             64'((CSUM_ON || i != n - 1) ? 1 : 0));
            end
        end
        check_output({tag, "_err"}, 64'(bus.err), 64'(CSUM_ON && bad_csum));
        check_output({tag, "_hold"}, 64'(bus.core_hold), 64'(CSUM_ON && bad_csum));
        check_output({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] n;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_we", 64'(bus.we), 64'd0);
        check_output("rst_waddr", 64'(bus.waddr), 64'd0);
        check_output("rst_wdata", 64'(bus.wdata), 64'd0);
        check_output("rst_hold", 64'(bus.core_hold), 64'd1);
        check_output("rst_err", 64'(bus.err), 64'd0);
        check_output("rst_ready", 64'(bus.in_ready), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic two-word load");
        img_words = '{32'hDEADBEEF, 32'h12345678};
        run_image(0, 1'b0, "basic");

        $display("[TB] empty image");
        do_restart();
        got_addr.delete();
        img_words.delete();
        build_image(1'b0);
        apply_stimulus(0);
        check_output("empty_hold", 64'(bus.core_hold), 64'd0);
        repeat (4) @(negedge clk);
        check_output("empty_no_we", 64'(got_addr.size()), 64'd0);
        check_output("empty_ready", 64'(bus.in_ready), 64'd0);

        $display("[TB] oversize header");
        do_restart();
        got_addr.delete();
        n = (32'd1 << W) + 32'd1;
        tx_bytes = '{n[31:24], n[23:16], n[15:8], n[7:0]};
        apply_stimulus(0);
        repeat (4) @(negedge clk);
        check_output("over_err", 64'(bus.err), 64'd1);
        check_output("over_ready", 64'(bus.in_ready), 64'd0);
        check_output("over_hold", 64'(bus.core_hold), 64'd1);
        check_output("over_no_we", 64'(got_addr.size()), 64'd0);

        $display("[TB] header at exact capacity");
        do_restart();
        n = 32'd1 << W;
        tx_bytes = '{n[31:24], n[23:16], n[15:8], n[7:0]};
        apply_stimulus(0);
        check_output("cap_err", 64'(bus.err), 64'd0);
        check_output("cap_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] restart mid-word");
        do_restart();
        got_addr.delete();
        tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
        apply_stimulus(0);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        bus.restart  = 1'b1;
        #1;
        check_output("mid_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.restart  = 1'b0;
        bus.in_valid = 1'b0;
        img_words = '{32'hAABBCCDD};
        run_image(0, 1'b0, "mid");

        $display("[TB] toggling in_valid");
        do_restart();
        img_words = '{32'hDEADBEEF, 32'h12345678};
        run_image(1, 1'b0, "toggle");

        $display("[TB] random images");
        for (int it = 0; it < 6; it++) begin
            int cnt;
            do_restart();
            cnt = int'($urandom_range(1, 6));
            img_words.delete();
            for (int k = 0; k < cnt; k++) img_words.push_back($urandom);
            run_image(2, 1'b0, "rand");
        end

        if (CSUM_ON) begin
            $display("[TB] checksum match and mismatch");
            do_restart();
            img_words = '{32'h01020304};
            run_image(0, 1'b0, "csum_ok");
            do_restart();
            run_image(0, 1'b1, "csum_bad");
            do_restart();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
